// File: rtl/mul_exec_unit.sv
// mul_exec_unit: iterative shift-add MUL/MLA stage with early termination and N/Z flag update
module mul_exec_unit #(
    parameter int DATA_WIDTH     = 32,
    parameter int ADDR_WIDTH     = 4,
    parameter int BITS_PER_CYCLE = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_WIDTH-1:0] rm,
    input  logic [DATA_WIDTH-1:0] rs,
    input  logic [DATA_WIDTH-1:0] rn,
    input  logic                  accumulate,
    input  logic                  set_flags,
    input  logic [ADDR_WIDTH-1:0] dest_addr,
    input  logic [DATA_WIDTH-1:0] cspr_in,
    output logic                  write_enable,
    output logic [ADDR_WIDTH-1:0] write_address,
    output logic [DATA_WIDTH-1:0] write_data,
    output logic                  cspr_write,
    output logic [DATA_WIDTH-1:0] cspr_update,
    output logic                  busy
);
    typedef enum logic [1:0] {IDLE, CALC, WB} state_t;
    state_t                state_q, state_d;
    logic [DATA_WIDTH-1:0] mcand_q, mcand_d;
    logic [DATA_WIDTH-1:0] mplier_q, mplier_d;
    logic [DATA_WIDTH-1:0] acc_q, acc_d;
    logic [ADDR_WIDTH-1:0] dest_q, dest_d;
    logic                  flags_q, flags_d;
    logic                  we_q, we_d;
    logic                  cw_q, cw_d;
    logic [ADDR_WIDTH-1:0] waddr_q, waddr_d;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
    logic [DATA_WIDTH-1:0] cspr_q, cspr_d;
    logic                  busy_q, busy_d;
    logic [DATA_WIDTH-1:0] step_acc;
    logic                  accept;
    assign in_ready      = (state_q == IDLE) && !rst;
    assign accept        = in_valid && in_ready;
    assign write_enable  = we_q;
    assign cspr_write    = cw_q;
    assign write_address = waddr_q;
    assign write_data    = wdata_q;
    assign cspr_update   = cspr_q;
    assign busy          = busy_q;
    // Retire BITS_PER_CYCLE multiplier bits: add each selected shifted multiplicand
    always_comb begin
        step_acc = acc_q;
        for (int i = 0; i < BITS_PER_CYCLE; i++)
            if (mplier_q[i]) step_acc = step_acc + (mcand_q << i);
    end
    // Next-state and registered-output logic; result is captured on the CALC->WB transition
    always_comb begin
        state_d  = state_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        acc_d    = acc_q;
        dest_d   = dest_q;
        flags_d  = flags_q;
        we_d     = 1'b0;
        cw_d     = 1'b0;
        waddr_d  = waddr_q;
        wdata_d  = wdata_q;
        cspr_d   = cspr_q;
        case (state_q)
            IDLE: if (accept) begin
                state_d  = CALC;
                mcand_d  = rm;
                mplier_d = rs;
                acc_d    = accumulate ? rn : '0;
                dest_d   = dest_addr;
                flags_d  = set_flags;
            end
            CALC: begin
                mcand_d  = mcand_q << BITS_PER_CYCLE;
                mplier_d = mplier_q >> BITS_PER_CYCLE;
                acc_d    = step_acc;
                if (mplier_d == '0) begin
                    state_d = WB;
                    we_d    = 1'b1;
                    waddr_d = dest_q;
                    wdata_d = step_acc;
                    cw_d    = flags_q;
                    cspr_d  = flags_q ? {step_acc[DATA_WIDTH-1], step_acc == '0, cspr_in[DATA_WIDTH-3:0]} : cspr_q;
                end
            end
            default: state_d = IDLE;
        endcase
        busy_d = state_d != IDLE;
    end
    // State and output registers with synchronous reset taking priority over any accept
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            mcand_q  <= '0;
            mplier_q <= '0;
            acc_q    <= '0;
            dest_q   <= '0;
            flags_q  <= 1'b0;
            we_q     <= 1'b0;
            cw_q     <= 1'b0;
            waddr_q  <= '0;
            wdata_q  <= '0;
            cspr_q   <= '0;
            busy_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            acc_q    <= acc_d;
            dest_q   <= dest_d;
            flags_q  <= flags_d;
            we_q     <= we_d;
            cw_q     <= cw_d;
            waddr_q  <= waddr_d;
            wdata_q  <= wdata_d;
            cspr_q   <= cspr_d;
            busy_q   <= busy_d;
        end
    end
endmodule

// File: tb/tb_mul_exec_unit.sv
// tb_mul_exec_unit: directed self-checking bench for the iterative multiplier stage
module tb_mul_exec_unit;
    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] rm, rs, rn, cspr_in;
    logic        accumulate, set_flags;
    logic [3:0]  dest_addr;
    logic        write_enable, cspr_write, busy;
    logic [3:0]  write_address;
    logic [31:0] write_data, cspr_update;
    int          checks = 0;
    int          failures = 0;
    int          n;
    logic        seen;
    mul_exec_unit dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .rm(rm), .rs(rs), .rn(rn), .accumulate(accumulate), .set_flags(set_flags),
        .dest_addr(dest_addr), .cspr_in(cspr_in), .write_enable(write_enable),
        .write_address(write_address), .write_data(write_data), .cspr_write(cspr_write),
        .cspr_update(cspr_update), .busy(busy)
    );
    always #5 clk = ~clk;
    task automatic tick();
        @(posedge clk);
        #1;
    endtask
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask
    task automatic run_op(input string tag, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] c, input logic acc, input logic sf,
                          input logic [3:0] d, input logic [31:0] csp, input int exp_calc,
                          input logic [31:0] exp_data, input logic [31:0] exp_cspr);
        int k;
        rm = a; rs = b; rn = c; accumulate = acc; set_flags = sf; dest_addr = d; cspr_in = csp;
        in_valid = 1'b1;
        chk({tag, "_ready"}, {31'b0, in_ready}, 32'd1);
        tick();
        in_valid = 1'b0;
        rm = 32'hDEAD_BEEF; rs = 32'hFFFF_FFFF; rn = 32'h5555_5555; dest_addr = 4'hF;
        chk({tag, "_busy"}, {31'b0, busy}, 32'd1);
        k = 0;
        while (!write_enable && k < 40) begin
            tick();
            k++;
        end
        chk({tag, "_calc_cycles"}, k, exp_calc);
        chk({tag, "_data"}, write_data, exp_data);
        chk({tag, "_addr"}, {28'b0, write_address}, {28'b0, d});
        chk({tag, "_cw"}, {31'b0, cspr_write}, {31'b0, sf});
        if (sf) chk({tag, "_cspr"}, cspr_update, exp_cspr);
        tick();
        chk({tag, "_we_drop"}, {30'b0, write_enable, cspr_write}, 32'd0);
        chk({tag, "_idle"}, {30'b0, busy, in_ready}, 32'd1);
    endtask
    initial begin
        rst = 1'b1; in_valid = 1'b0; rm = '0; rs = '0; rn = '0; cspr_in = '0;
        accumulate = 1'b0; set_flags = 1'b0; dest_addr = '0;
        tick();
        tick();
        chk("reset_ready", {31'b0, in_ready}, 32'd0);
        chk("reset_outs", {29'b0, write_enable, cspr_write, busy}, 32'd0);
        chk("reset_data", write_data | cspr_update | {28'b0, write_address}, 32'd0);
        rst = 1'b0;
        #1;
        chk("post_reset_ready", {31'b0, in_ready}, 32'd1);
        run_op("t1_mul", 32'd2, 32'd2, 32'd0, 1'b0, 1'b0, 4'd2, 32'd0, 1, 32'h4, 32'd0);
        run_op("t2_flags", 32'd3, 32'hFFFF_FFFF, 32'd0, 1'b0, 1'b1, 4'd9, 32'h2000_0000,
               16, 32'hFFFF_FFFD, 32'hA000_0000);
        run_op("t3_mla", 32'd5, 32'd7, 32'd10, 1'b1, 1'b0, 4'd3, 32'd0, 2, 32'h2D, 32'd0);
        run_op("t4_zero", 32'h1234, 32'd0, 32'd0, 1'b0, 1'b1, 4'd4, 32'd0, 1, 32'd0, 32'h4000_0000);
        run_op("t4b_mla_wrap", 32'h8000_0001, 32'd3, 32'hFFFF_FFFF, 1'b1, 1'b1, 4'd6,
               32'h3FFF_FFFF, 1, 32'h8000_0002, 32'hBFFF_FFFF);
        rm = 32'd2; rs = 32'd3; rn = '0; accumulate = 1'b0; set_flags = 1'b0; dest_addr = 4'd1;
        in_valid = 1'b1;
        tick();
        rm = 32'd7; rs = 32'd9; dest_addr = 4'd5;
        chk("t5_ready_calc", {31'b0, in_ready}, 32'd0);
        tick();
        chk("t5_first_we", {31'b0, write_enable}, 32'd1);
        chk("t5_first_data", write_data, 32'd6);
        chk("t5_first_addr", {28'b0, write_address}, 32'd1);
        chk("t5_ready_wb", {31'b0, in_ready}, 32'd0);
        tick();
        chk("t5_idle_ready", {30'b0, in_ready, write_enable}, 32'd2);
        tick();
        in_valid = 1'b0;
        chk("t5_second_busy", {30'b0, busy, in_ready}, 32'd2);
        tick();
        chk("t5_second_calc", {31'b0, write_enable}, 32'd0);
        tick();
        chk("t5_second_we", {31'b0, write_enable}, 32'd1);
        chk("t5_second_data", write_data, 32'd63);
        chk("t5_second_addr", {28'b0, write_address}, 32'd5);
        tick();
        rm = 32'd1; rs = 32'hFFFF_FFFF; set_flags = 1'b1; dest_addr = 4'd7; cspr_in = 32'h2000_0000;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        for (int i = 0; i < 4; i++) tick();
        chk("t6_mid_calc", {31'b0, busy}, 32'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        #1;
        chk("t6_rst_outs", {29'b0, write_enable, cspr_write, busy}, 32'd0);
        chk("t6_rst_data", write_data | cspr_update | {28'b0, write_address}, 32'd0);
        chk("t6_rst_ready", {31'b0, in_ready}, 32'd1);
        seen = 1'b0;
        for (int i = 0; i < 20; i++) begin
            tick();
            seen = seen | write_enable | cspr_write | busy;
        end
        chk("t6_no_write", {31'b0, seen}, 32'd0);
        in_valid = 1'b1; rst = 1'b1;
        tick();
        rst = 1'b0; in_valid = 1'b0;
        #1;
        chk("t6_rst_priority", {31'b0, busy}, 32'd0);
        run_op("t6_after", 32'd6, 32'd7, 32'd0, 1'b0, 1'b0, 4'd8, 32'd0, 2, 32'd42, 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
